burst_ram_ctrl: RTL and testbench

//  Burst-oriented RAM endpoint sitting directly downstream of the cache arbiter's br_* port.

---
 rtl/burst_ram_pkg.sv | 15 +
 rtl/burst_ram_if.sv | 26 ++
 rtl/burst_ram_array.sv | 36 +++
 rtl/burst_ram_ctrl.sv | 136 +++++++++++++
 tb/tb_burst_ram_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/burst_ram_pkg.sv
// burst_ram_pkg: command codes and one-hot FSM states shared by the burst RAM endpoint.
package burst_ram_pkg;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [4:0] {
        ST_INIT        = 5'b00001,
        ST_IDLE        = 5'b00010,
        ST_READ_WAIT   = 5'b00100,
        ST_READ_BURST  = 5'b01000,
        ST_WRITE_BURST = 5'b10000
    } state_t;

endpackage

// File: rtl/burst_ram_if.sv
// burst_ram_if: command/data bus between a cache arbiter (master) and the burst RAM (slave).
interface burst_ram_if #(
    parameter int DEPTH_BITWIDTH = 4,
    parameter int DATA_BITWIDTH  = 64
);

    logic                         cmd;
    logic                         cmd_en;
    logic [DEPTH_BITWIDTH-1:0]    addr;
    logic [DATA_BITWIDTH-1:0]     wr_data;
    logic [DATA_BITWIDTH/8-1:0]   data_mask;
    logic [DATA_BITWIDTH-1:0]     rd_data;
    logic                         rd_data_valid;
    logic                         busy;

    modport master (
        output cmd, cmd_en, addr, wr_data, data_mask,
        input  rd_data, rd_data_valid, busy
    );

    modport slave (
        input  cmd, cmd_en, addr, wr_data, data_mask,
        output rd_data, rd_data_valid, busy
    );

endinterface

// File: rtl/burst_ram_array.sv
// burst_ram_array: single-port word array, byte-enabled sync write, registered sync read.
module burst_ram_array #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic                  we_i,
    input  logic [DATA_W/8-1:0]   be_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic                  re_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Contents survive reset; only enabled bytes of the addressed word are updated.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    // Read register loads only on a read strobe so the last beat is held between bursts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/burst_ram_ctrl.sv
// burst_ram_ctrl: burst RAM endpoint with init delay, fixed read latency and busy handshake.
// Optional feature: define BURST_RAM_BYTE_MASK_EN to honour data_mask on write beats.
module burst_ram_ctrl
    import burst_ram_pkg::*;
#(
    parameter int DEPTH_BITWIDTH           = 4,
    parameter int DATA_BITWIDTH            = 64,
    parameter int BURST_COUNT              = 4,
    parameter int CYCLES_BEFORE_DATA_VALID = 6,
    parameter int CYCLES_BEFORE_INITIATED  = 10
) (
    input logic       clk,
    input logic       rst_n,
    burst_ram_if.slave bus
);

    localparam int LAT_W  = $clog2(CYCLES_BEFORE_DATA_VALID + 1);
    localparam int BEAT_W = $clog2(BURST_COUNT);
    localparam int INIT_W = $clog2(CYCLES_BEFORE_INITIATED + 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(CYCLES_BEFORE_DATA_VALID - 2);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_COUNT - 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(CYCLES_BEFORE_INITIATED - 1);

    state_t                    state_q;
    logic [LAT_W-1:0]          lat_q;
    logic [BEAT_W-1:0]         beat_q;
    logic [INIT_W-1:0]         init_q;
    logic [DEPTH_BITWIDTH-1:0] ptr_q;
    logic                      busy_q;
    logic                      valid_q;

    logic                       is_write;
    logic                       we;
    logic                       re;
    logic [DEPTH_BITWIDTH-1:0]  arr_addr;
    logic [DATA_BITWIDTH/8-1:0] be;

    // Beat 0 of a write goes straight to the array in the accept cycle using the bus address;
    // the read strobe is issued one cycle ahead of each beat to cover the array's read register.
    always_comb begin
        is_write = bus.cmd == CMD_WRITE;
        we       = (state_q == ST_IDLE && bus.cmd_en && is_write) || state_q == ST_WRITE_BURST;
        re       = (state_q == ST_READ_WAIT && lat_q == LAT_LAST) ||
                   (state_q == ST_READ_BURST && beat_q != BEAT_LAST);
        arr_addr = state_q == ST_IDLE ? bus.addr : ptr_q;
    end

`ifdef BURST_RAM_BYTE_MASK_EN
    assign be = ~bus.data_mask;
`else
    logic unused_mask;
    assign unused_mask = ^bus.data_mask;
    assign be = '1;
`endif

    // Control FSM: counters, burst address pointer and the registered busy/valid outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            lat_q   <= '0;
            beat_q  <= '0;
            init_q  <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    init_q <= init_q + INIT_W'(1);
                    if (init_q == INIT_LAST) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (bus.cmd_en) begin
                        state_q <= is_write ? ST_WRITE_BURST : ST_READ_WAIT;
                        busy_q  <= 1'b1;
                        lat_q   <= '0;
                        beat_q  <= is_write ? BEAT_W'(1) : '0;
                        ptr_q   <= is_write ? bus.addr + DEPTH_BITWIDTH'(1) : bus.addr;
                    end
                end
                ST_READ_WAIT: begin
                    lat_q <= lat_q + LAT_W'(1);
                    if (lat_q == LAT_LAST) begin
                        state_q <= ST_READ_BURST;
                        valid_q <= 1'b1;
                        ptr_q   <= ptr_q + DEPTH_BITWIDTH'(1);
                    end
                end
                ST_READ_BURST: begin
                    beat_q <= beat_q + BEAT_W'(1);
                    ptr_q  <= ptr_q + DEPTH_BITWIDTH'(1);
                    if (beat_q == BEAT_LAST) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                ST_WRITE_BURST: begin
                    beat_q <= beat_q + BEAT_W'(1);
                    ptr_q  <= ptr_q + DEPTH_BITWIDTH'(1);
                    if (beat_q == BEAT_LAST) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    busy_q  <= 1'b1;
                    valid_q <= 1'b0;
                    init_q  <= '0;
                end
            endcase
        end
    end

    burst_ram_array #(
        .ADDR_W (DEPTH_BITWIDTH),
        .DATA_W (DATA_BITWIDTH)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr_i  (arr_addr),
        .we_i    (we),
        .be_i    (be),
        .wdata_i (bus.wr_data),
        .re_i    (re),
        .rdata_o (bus.rd_data)
    );

    assign bus.busy          = busy_q;
    assign bus.rd_data_valid = valid_q;

endmodule

// File: tb/tb_burst_ram_ctrl.sv
// tb_burst_ram_ctrl: randomized and directed bench for burst_ram_ctrl against a cycle-indexed model.
module tb_burst_ram_ctrl;
    import burst_ram_pkg::*;

    localparam int AW   = 4;
    localparam int DW   = 64;
    localparam int BC   = 4;
    localparam int CBDV = 6;
    localparam int CBI  = 10;
    localparam int NW   = 2**AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    burst_ram_if #(.DEPTH_BITWIDTH(AW), .DATA_BITWIDTH(DW)) bus();

    burst_ram_ctrl #(
        .DEPTH_BITWIDTH(AW), .DATA_BITWIDTH(DW), .BURST_COUNT(BC),
        .CYCLES_BEFORE_DATA_VALID(CBDV), .CYCLES_BEFORE_INITIATED(CBI)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Model: word array, expected read beats keyed by cycle, first cycle the endpoint is free.
    logic [DW-1:0] mdl [NW];
    logic [DW-1:0] exp_rd [int];
    int            ready_at = 0;
    logic [DW-1:0] last_q = '0;
    logic          ev;

    logic [DW-1:0] wd [BC];
    logic [7:0]    wm [BC];
    logic [DW-1:0] bq [$];
    int            bcy [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [7:0] m);
`ifdef BURST_RAM_BYTE_MASK_EN
        merge = old;
        for (int b = 0; b < 8; b++) if (!m[b]) merge[b*8 +: 8] = d[b*8 +: 8];
`else
        merge = d | (old & '0) | DW'(m & 8'h0);
`endif
    endfunction

    function automatic logic [DW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Compare DUT against the model every cycle, and record observed beats.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_q = '0;
            chk("rst_busy", bus.busy, 1);
            chk("rst_valid", bus.rd_data_valid, 0);
            chk("rst_data", bus.rd_data, 0);
        end else begin
            chk("busy", bus.busy, cyc < ready_at);
            ev = exp_rd.exists(cyc);
            chk("valid", bus.rd_data_valid, ev);
            if (ev) last_q = exp_rd[cyc];
            chk("rd_data", bus.rd_data, last_q);
        end
        if (rst_n && bus.rd_data_valid) begin
            bq.push_back(bus.rd_data);
            bcy.push_back(cyc);
        end
    end

    task automatic accept(input logic c, input logic [AW-1:0] a);
        for (int k = 0; k < BC; k++) begin
            logic [AW-1:0] p;
            p = a + AW'(k);
            if (c == CMD_WRITE) mdl[p] = merge(mdl[p], wd[k], wm[k]);
            else exp_rd[cyc + CBDV + k] = mdl[p];
        end
        ready_at = cyc + (c == CMD_WRITE ? BC : CBDV + BC);
    endtask

    // en: 0 never, 1 always, 2 random while busy, 3 always while busy.
    task automatic drive(input int en, input logic c, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [7:0] m);
        logic e;
        @(negedge clk);
        #1;
        e = (en == 1) || (cyc < ready_at && (en == 3 || (en == 2 && $urandom_range(0, 1) == 1)));
        bus.cmd_en = e;
        bus.cmd = c;
        bus.addr = a;
        bus.wr_data = d;
        bus.data_mask = m;
        if (e && rst_n && cyc >= ready_at) accept(c, a);
    endtask

    task automatic noise(input int en, input logic [DW-1:0] d, input logic [7:0] m);
        drive(en, 1'($urandom), AW'($urandom), d, m);
    endtask

    task automatic burst(input logic c, input logic [AW-1:0] a, input int stray, output int t);
        drive(1, c, a, wd[0], wm[0]);
        t = cyc;
        for (int k = 1; k < BC; k++)
            noise(stray, c == CMD_WRITE ? wd[k] : rnd64(), c == CMD_WRITE ? wm[k] : 8'($urandom));
        while (cyc + 1 < ready_at) noise(stray, rnd64(), 8'($urandom));
    endtask

    task automatic do_reset(input int hold);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        bus.cmd_en = 1'b0;
        exp_rd.delete();
        repeat (hold) @(posedge clk);
        #2;
        rst_n = 1'b1;
        ready_at = cyc + CBI;
    endtask

    task automatic wait_ready();
        while (cyc + 1 < ready_at) noise(2, rnd64(), 8'($urandom));
    endtask

    task automatic set_words(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                             input logic [DW-1:0] w2, input logic [DW-1:0] w3, input logic [7:0] m);
        wd[0] = w0; wd[1] = w1; wd[2] = w2; wd[3] = w3;
        for (int k = 0; k < BC; k++) wm[k] = m;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int rel;
        int lowat;
        logic [DW-1:0] e0, e1, e2, e3;
        bus.cmd_en = 1'b0;
        bus.cmd = CMD_READ;
        bus.addr = '0;
        bus.wr_data = '0;
        bus.data_mask = '0;
        for (int k = 0; k < BC; k++) begin wd[k] = '0; wm[k] = '0; end

        // Reset release: busy must stay high through cycle rel+9 and drop at rel+10.
        do_reset(3);
        rel = cyc;
        lowat = -1;
        for (int i = 0; i <= CBI; i++) begin
            noise(2, rnd64(), 8'($urandom));
            if (!bus.busy && lowat < 0) lowat = cyc - rel;
        end
        chk("init_busy_len", lowat, 10);

        // Fill the whole array so every later read has a known value.
        for (int a = 0; a < NW; a += BC) begin
            set_words(rnd64(), rnd64(), rnd64(), rnd64(), 8'h00);
            burst(CMD_WRITE, AW'(a), 2, t);
        end

        // Write then read a burst at address 4.
        set_words(64'h1111111111111111, 64'h2222222222222222,
                  64'h3333333333333333, 64'h4444444444444444, 8'h00);
        burst(CMD_WRITE, 4'd4, 0, t);
        bq.delete(); bcy.delete();
        burst(CMD_READ, 4'd4, 0, t);
        chk("t2_beats", bq.size(), 4);
        if (bq.size() == 4) begin
            chk("t2_b0", bq[0], 64'h1111111111111111);
            chk("t2_b1", bq[1], 64'h2222222222222222);
            chk("t2_b2", bq[2], 64'h3333333333333333);
            chk("t2_b3", bq[3], 64'h4444444444444444);
            chk("t2_first_cyc", bcy[0] - t, 6);
            chk("t2_last_cyc", bcy[3] - t, 9);
        end
        noise(0, rnd64(), 8'h00);
        chk("t2_busy_T10", bus.busy, 0);

        // Wrap at the top of the array.
        set_words(64'hA1A1A1A1A1A1A1A1, 64'hB2B2B2B2B2B2B2B2,
                  64'hC3C3C3C3C3C3C3C3, 64'hD4D4D4D4D4D4D4D4, 8'h00);
        burst(CMD_WRITE, 4'd14, 0, t);
        bq.delete(); bcy.delete();
        burst(CMD_READ, 4'd0, 0, t);
        chk("t3_beats", bq.size(), 4);
        if (bq.size() == 4) begin
            chk("t3_b0", bq[0], 64'hC3C3C3C3C3C3C3C3);
            chk("t3_b1", bq[1], 64'hD4D4D4D4D4D4D4D4);
        end

        // Byte mask over an all-ones burst at address 8.
        set_words('1, '1, '1, '1, 8'h00);
        burst(CMD_WRITE, 4'd8, 0, t);
        set_words('0, '0, '0, '0, 8'h00);
        wm[0] = 8'hF0; wm[1] = 8'h0F; wm[2] = 8'h00; wm[3] = 8'hFF;
        burst(CMD_WRITE, 4'd8, 0, t);
        bq.delete(); bcy.delete();
        burst(CMD_READ, 4'd8, 0, t);
`ifdef BURST_RAM_BYTE_MASK_EN
        e0 = 64'hFFFFFFFF_00000000; e1 = 64'h00000000_FFFFFFFF; e2 = '0; e3 = '1;
`else
        e0 = '0; e1 = '0; e2 = '0; e3 = '0;
`endif
        chk("t4_beats", bq.size(), 4);
        if (bq.size() == 4) begin
            chk("t4_b0", bq[0], e0);
            chk("t4_b1", bq[1], e1);
            chk("t4_b2", bq[2], e2);
            chk("t4_b3", bq[3], e3);
        end

        // Commands strobed while a read is in flight must be ignored.
        bq.delete(); bcy.delete();
        burst(CMD_READ, 4'd4, 3, t);
        chk("t5_beats", bq.size(), 4);
        bq.delete(); bcy.delete();
        burst(CMD_READ, 4'd4, 0, t);
        chk("t5_reread_beats", bq.size(), 4);
        if (bq.size() == 4) begin
            chk("t5_b0", bq[0], 64'h1111111111111111);
            chk("t5_b3", bq[3], 64'h4444444444444444);
        end

        // Reset on the second read beat aborts the burst; contents survive.
        bq.delete(); bcy.delete();
        drive(1, CMD_READ, 4'd4, rnd64(), 8'h00);
        t = cyc;
        for (int k = 0; k < CBDV; k++) noise(0, rnd64(), 8'h00);
        do_reset(3);
        chk("t6_beats_before_rst", bq.size(), 1);
        if (bq.size() == 1) chk("t6_beat_cyc", bcy[0] - t, 6);
        wait_ready();
        bq.delete(); bcy.delete();
        burst(CMD_READ, 4'd4, 0, t);
        chk("t6_beats", bq.size(), 4);
        if (bq.size() == 4) begin
            chk("t6_b0", bq[0], 64'h1111111111111111);
            chk("t6_b1", bq[1], 64'h2222222222222222);
            chk("t6_b2", bq[2], 64'h3333333333333333);
            chk("t6_b3", bq[3], 64'h4444444444444444);
        end

        // Randomized traffic with stray strobes, checked cycle by cycle by the model.
        for (int i = 0; i < 80; i++) begin
            set_words(rnd64(), rnd64(), rnd64(), rnd64(), 8'h00);
            for (int k = 0; k < BC; k++) wm[k] = 8'($urandom);
            burst(1'($urandom), AW'($urandom), 2, t);
            repeat ($urandom_range(0, 2)) noise(0, rnd64(), 8'($urandom));
        end
        repeat (3) noise(0, rnd64(), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
